shiftrow_enc_stream: RTL and testbench
======================================

// Module: shiftrow_enc_stream
// PURPOSE
//  Encrypt-side counterpart of the decrypt inverse-ShiftRows block.
//  - Deserialises a byte stream into 128-bit AES states.
//  - Applies forward ShiftRows to each state.
//  - Queues results in a small FIFO and presents them on a 128-bit valid/ready port.
//  - Sits between a byte-wide key/data loader and the encrypt round datapath.
// PARAMETERS
//  FIFO_DEPTH  2  output state FIFO entries; power of two, >=2
// PORTS
//  clk        in   1    single clock, all logic rising-edge
//  rst        in   1    synchronous reset, active-high
//  in_byte    in   8    state byte; byte k (k=0..15) maps to bits [127-8k -: 8]
//  in_valid   in   1    in_byte valid
//  in_ready   out  1    byte accepted when in_valid & in_ready
//  out_state  out  128  forward-ShiftRows result, FIFO head
//  out_valid  out  1    FIFO non-empty
//  out_ready  in   1    head consumed when out_valid & out_ready
//  busy       out  1    partial block held (byte count != 0)
//  fifo_cnt   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Clock and reset:
//  - One clock; reset is synchronous and active-high.
//  - Reset: byte count=0, FIFO empty, out_valid=0, busy=0, fifo_cnt=0, out_state=0.
//  - Reset mid-block discards the partial block and all queued states.
//  Byte assembly:
//  - Byte order: first accepted byte is k=0 (bits [127:120]), last is k=15 ([7:0]).
//  - A 4-bit count cnt increments on each accepted byte and wraps 15->0.
//  - Byte k is written into assembly register slot k.
//  ShiftRows mapping:
//  - Byte k sits at row r=k%4, col c=k/4.
//  - Forward ShiftRows: out[r][c] = in[r][(c+r)%4].
//    e.g. out[119:112] = in[87:80]; out[111:104] = in[47:40]; out[103:96] = in[7:0].
//  Push on the 16th byte:
//  - The 16th accepted byte (cnt==15) completes the block.
//  - The block, including that byte taken combinationally from in_byte, is
//    permuted and pushed into the FIFO in the same cycle.
//  - The pushed state is visible on out_state/out_valid the next cycle when the
//    FIFO was empty. Latency: last byte accepted -> out_valid high = 1 cycle.
//  in_ready rule:
//  - in_ready = (cnt != 15) | (fifo_cnt < FIFO_DEPTH).
//  - Registered terms only; no combinational path from out_ready to in_ready.
//  - Bytes 0..14 are always accepted. Only the completing byte stalls on a full FIFO.
//  Output handshake:
//  - out_valid = (fifo_cnt != 0). out_state = head entry; it is held stable while
//    out_valid & !out_ready.
//  - Simultaneous push and pop with 0 < fifo_cnt < FIFO_DEPTH: fifo_cnt is unchanged
//    and order is preserved.
//  - Full FIFO with pop and a completing byte in the same cycle: the byte is NOT
//    accepted (in_ready=0). The pop proceeds and the byte is accepted next cycle.
//  - Pop on empty and push on full cannot occur.
//  Misc:
//  - Read/write pointers wrap modulo FIFO_DEPTH.
//  - busy = (cnt != 0).
//  - in_byte is ignored when in_valid=0; cnt holds.
// TESTING
//  1. Reset, stream bytes 00..0F back-to-back with out_ready=1:
//     -> 1 cycle after byte 0F, out_valid=1 and
//        out_state=00050A0F_04090E03_080D0207_0C01060B.
//  2. out_ready=0, stream 3 blocks (DEPTH=2):
//     -> fifo_cnt reaches 2, and in_ready=0 only once cnt==15 on the third block.
//     -> Raise out_ready: third block is accepted 1 cycle later; outputs emerge in order.
//  3. Blocks of all-AA, then bytes k=k*0x11:
//     -> first output all-AA; second = 00_55_AA_FF_44_99_EE_33_88_DD_22_77_CC_11_66_BB.
//  4. Assert rst after 7 bytes of a block with 1 state queued:
//     -> next cycle out_valid=0, busy=0, fifo_cnt=0.
//     -> A fresh 16-byte block then yields the correct single output.
//  5. Random in_valid/out_ready gaps over 1000 random blocks vs a reference model:
//     -> every output matches forward ShiftRows.
//     -> out_state is stable while stalled; no loss or duplication.

Source files
------------

// File: rtl/shiftrow_enc_stream.sv
// Byte-stream to 128-bit AES state deserialiser with forward ShiftRows and a
// small output FIFO on a valid/ready port, feeding the encrypt round datapath.
module shiftrow_enc_stream #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    in_byte,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [127:0]                  out_state,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   // Byte k sits at row k%4, column k/4; output (r,c) takes input (r,(c+r)%4).
   function automatic logic [127:0] shift_rows(input logic [127:0] st);
      logic [127:0] res;
      int           src;
      res = 128'd0;
      for (int k = 0; k < 16; k++) begin
         src = (k % 4) + 4 * (((k / 4) + (k % 4)) % 4);
         res[127 - 8*k -: 8] = st[127 - 8*src -: 8];
      end
      return res;
   endfunction

   logic [3:0]    cnt_r;
   logic [7:0]    asm_r [16];
   logic [127:0]  mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] occ_r;
   logic [127:0]  block_s;
   logic          accept_s;
   logic          push_s;
   logic          pop_s;

   // Completing byte bypasses the assembly register so the push happens this cycle.
   always_comb begin
      block_s = 128'd0;
      for (int k = 0; k < 15; k++) begin
         block_s[127 - 8*k -: 8] = asm_r[k];
      end
      block_s[7:0] = in_byte;
   end

   assign in_ready  = (cnt_r != 4'd15) | (occ_r < CW'(FIFO_DEPTH));
   assign accept_s  = in_valid & in_ready;
   assign push_s    = accept_s & (cnt_r == 4'd15);
   assign pop_s     = out_valid & out_ready;
   assign out_valid = (occ_r != {CW{1'b0}});
   assign out_state = mem_r[rd_ptr_r];
   assign busy      = (cnt_r != 4'd0);
   assign fifo_cnt  = occ_r;

   // Byte counter and assembly slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= 4'd0;
         for (int k = 0; k < 16; k++) begin
            asm_r[k] <= 8'd0;
         end
      end else if (accept_s) begin
         cnt_r        <= cnt_r + 4'd1;
         asm_r[cnt_r] <= in_byte;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         occ_r    <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 128'd0;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= shift_rows(block_s);
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + CW'(1);
            2'b01:   occ_r <= occ_r - CW'(1);
            default: occ_r <= occ_r;
         endcase
      end
   end

endmodule

// File: tb/tb_shiftrow_enc_stream.sv
// Scoreboard bench for shiftrow_enc_stream: directed vectors plus a random
// gapped stream checked against an independent ShiftRows model.
module tb_shiftrow_enc_stream;

   localparam int DEPTH = 2;
   localparam logic [127:0] B1 = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] E1 = 128'h00050A0F_04090E03_080D0207_0C01060B;
   localparam logic [127:0] BA = {16{8'hAA}};
   localparam logic [127:0] B3 = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] E3 = 128'h0055AAFF_4499EE33_88DD2277_CC1166BB;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_byte;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] out_state;
   logic         out_valid;
   logic         out_ready;
   logic         busy;
   logic [1:0]   fifo_cnt;

   int           n_checks = 0;
   int           n_pass = 0;
   logic [127:0] exp_q [$];
   bit           rand_rdy = 1'b0;
   bit           hold_prev = 1'b0;
   logic [127:0] prev_state = 128'd0;

   shiftrow_enc_stream #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready), .out_state(out_state), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, got, want);
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %b, want %b", name, got, want);
   endtask

   // Reference model: build the 4x4 matrix, rotate row r left by r.
   function automatic logic [127:0] ref_sr(input logic [127:0] blk);
      logic [7:0]   s [4][4];
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = blk[127 - 8*(r + 4*c) -: 8];
      o = 128'd0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127 - 8*(r + 4*c) -: 8] = s[r][(c + r) % 4];
      return o;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit acc;
      int budget;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      in_byte  = b;
      in_valid = 1'b1;
      acc      = 1'b0;
      budget   = 0;
      while (!acc && budget < 1000) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         budget++;
      end
      in_valid = 1'b0;
      check_bit("byte_accepted", acc, 1'b1);
   endtask

   task automatic send_block(input logic [127:0] blk, input logic [127:0] exp, input bit gaps);
      exp_q.push_back(exp);
      for (int k = 0; k < 16; k++) send_byte(blk[127 - 8*k -: 8], gaps);
   endtask

   task automatic wait_drain();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 500) begin
         @(posedge clk); #1;
         budget++;
      end
      check("drain_left", 128'(exp_q.size()), 128'd0);
   endtask

   // Monitor: pops the scoreboard on every handshake, checks hold stability.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
         end else begin
            if (out_valid) begin
               if (hold_prev) check("hold_stable", out_state, prev_state);
               if (out_ready) begin
                  if (exp_q.size() == 0) check("extra_output", 128'(exp_q.size()), 128'd1);
                  else check("out_state", out_state, exp_q.pop_front());
               end
            end
            hold_prev  = out_valid & ~out_ready;
            prev_state = out_state;
         end
      end
   end

   // Random consumer back-pressure.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      logic [127:0] blk;
      rst = 1'b1; in_valid = 1'b0; in_byte = 8'd0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check("rst_fifo_cnt", 128'(fifo_cnt), 128'd0);
      check("rst_out_state", out_state, 128'd0);
      check_bit("rst_in_ready", in_ready, 1'b1);

      // 1: 00..0F back to back, one-cycle latency.
      out_ready = 1'b1;
      exp_q.push_back(E1);
      for (int k = 0; k < 16; k++) begin
         send_byte(B1[127 - 8*k -: 8], 1'b0);
         if (k == 7) check_bit("busy_mid_block", busy, 1'b1);
      end
      check_bit("latency_out_valid", out_valid, 1'b1);
      check_bit("busy_after_block", busy, 1'b0);
      wait_drain();

      // 2: fill the FIFO, the completing byte of block 3 stalls.
      out_ready = 1'b0;
      send_block(B1, E1, 1'b0);
      send_block(BA, BA, 1'b0);
      check("full_fifo_cnt", 128'(fifo_cnt), 128'd2);
      exp_q.push_back(E3);
      for (int k = 0; k < 15; k++) send_byte(B3[127 - 8*k -: 8], 1'b0);
      check_bit("stall_in_ready", in_ready, 1'b0);
      in_byte  = B3[7:0];
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_bit("stall_hold_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check_bit("no_ready_path", in_ready, 1'b0);
      @(posedge clk); #1;
      check("after_pop_cnt", 128'(fifo_cnt), 128'd1);
      @(negedge clk);
      check_bit("resume_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("push_pop_cnt", 128'(fifo_cnt), 128'd1);
      check_bit("busy_after_resume", busy, 1'b0);
      wait_drain();

      // 3: all-AA then k*0x11.
      send_block(BA, BA, 1'b0);
      send_block(B3, E3, 1'b0);
      wait_drain();

      // 4: reset mid-block with one state queued.
      out_ready = 1'b0;
      send_block(B3, E3, 1'b0);
      check("queued_one", 128'(fifo_cnt), 128'd1);
      for (int k = 0; k < 7; k++) send_byte(B1[127 - 8*k -: 8], 1'b0);
      check_bit("busy_partial", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_bit("mid_rst_out_valid", out_valid, 1'b0);
      check_bit("mid_rst_busy", busy, 1'b0);
      check("mid_rst_fifo_cnt", 128'(fifo_cnt), 128'd0);
      out_ready = 1'b1;
      send_block(B1, E1, 1'b0);
      wait_drain();

      // 5: random blocks with gaps and back-pressure.
      rand_rdy = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         blk = {$urandom, $urandom, $urandom, $urandom};
         send_block(blk, ref_sr(blk), 1'b1);
      end
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      @(posedge clk); #1;
      check("final_fifo_cnt", 128'(fifo_cnt), 128'd0);
      check_bit("final_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
